// File: rtl/heap_priority_queue.sv
// Binary-heap priority queue: PUSH / POP / REPLACE, one compare-and-swap per clock.
// Define HEAP_SIGNED_EN to compare keys as two's-complement signed values (unsigned otherwise).
module heap_priority_queue #(
  parameter int KEY_W    = 32,
  parameter int DEPTH    = 1023,
  parameter int CNT_W    = 10,
  parameter int MIN_HEAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       instruction,
  input  logic [KEY_W-1:0] key,
  output logic             done,
  output logic             busy,
  output logic             error,
  output logic [KEY_W-1:0] arr_out,
  output logic [KEY_W-1:0] pop_data,
  output logic [CNT_W-1:0] n,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);
  localparam logic [AW-1:0]    TOP     = '0;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN, FIN} state_t;

  state_t           state;
  logic [KEY_W-1:0] heap [DEPTH];
  logic [IW-1:0]    idx;
  logic             err_flag;

  logic [IW-1:0]    n_ext, parent, left, right, best;
  logic [KEY_W-1:0] cur_key, par_key, left_key, right_key, best_key, last_key;

  function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
`ifdef HEAP_SIGNED_EN
    if (MIN_HEAP != 0) return $signed(a) < $signed(b);
    else               return $signed(a) > $signed(b);
`else
    if (MIN_HEAP != 0) return a < b;
    else               return a > b;
`endif
  endfunction

  function automatic logic [AW-1:0] addr(input logic [IW-1:0] i);
    return i[AW-1:0];
  endfunction

  // Child indices are one bit wider than n, so 2*idx+2 never wraps near DEPTH.
  always_comb begin
    n_ext     = {1'b0, n};
    parent    = (idx - IW'(1)) >> 1;
    left      = (idx << 1) + IW'(1);
    right     = (idx << 1) + IW'(2);
    cur_key   = heap[addr(idx)];
    par_key   = heap[addr(parent)];
    left_key  = heap[addr(left)];
    right_key = heap[addr(right)];
    last_key  = heap[addr(n_ext - IW'(1))];
    best      = idx;
    best_key  = cur_key;
    if (left < n_ext && better(left_key, best_key)) begin
      best     = left;
      best_key = left_key;
    end
    if (right < n_ext && better(right_key, best_key)) begin
      best     = right;
      best_key = right_key;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n        <= '0;
      pop_data <= '0;
      err_flag <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_flag <= 1'b0;
          if (start) begin
            case (instruction)
              2'b01: begin
                if (full) begin
                  err_flag <= 1'b1;
                  state    <= FIN;
                end else begin
                  heap[addr(n_ext)] <= key;
                  n     <= n + 1'b1;
                  idx   <= n_ext;
                  state <= SIFT_UP;
                end
              end
              2'b10: begin
                if (empty) begin
                  err_flag <= 1'b1;
                  state    <= FIN;
                end else begin
                  pop_data  <= heap[TOP];
                  heap[TOP] <= last_key;
                  n         <= n - 1'b1;
                  idx       <= '0;
                  state     <= (n == CNT_W'(1)) ? FIN : SIFT_DOWN;
                end
              end
              2'b11: begin
                if (empty) begin
                  err_flag <= 1'b1;
                  state    <= FIN;
                end else begin
                  pop_data  <= heap[TOP];
                  heap[TOP] <= key;
                  idx       <= '0;
                  state     <= SIFT_DOWN;
                end
              end
              default: state <= FIN;
            endcase
          end
        end
        SIFT_UP: begin
          if (idx == '0 || !better(cur_key, par_key)) begin
            state <= FIN;
          end else begin
            heap[addr(idx)]    <= par_key;
            heap[addr(parent)] <= cur_key;
            idx                <= parent;
          end
        end
        SIFT_DOWN: begin
          if (best == idx) begin
            state <= FIN;
          end else begin
            heap[addr(idx)]  <= best_key;
            heap[addr(best)] <= cur_key;
            idx              <= best;
          end
        end
        FIN: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done    = (state == FIN);
  assign busy    = (state != IDLE);
  assign error   = err_flag;
  assign empty   = (n == '0);
  assign full    = (n == DEPTH_N);
  assign arr_out = empty ? '0 : heap[TOP];

endmodule

// File: tb/tb_heap_priority_queue.sv
// Directed bench: a min-heap instance (DEPTH=7) and a max-heap instance sharing one clock.
module tb_heap_priority_queue;

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

  logic        clk;
  logic [1:0]  instruction;
  logic [31:0] key;
  logic        rst_v [2];
  logic        start_v [2];
  logic        done_v [2], busy_v [2], err_v [2], full_v [2], empty_v [2];
  logic [31:0] top_v [2], pop_v [2];
  logic [2:0]  n_v [2];

  int checks = 0;
  int failures = 0;
  int lat;
  logic e;

  heap_priority_queue #(.KEY_W(32), .DEPTH(7), .CNT_W(3), .MIN_HEAP(1)) dut_min (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .instruction(instruction), .key(key),
    .done(done_v[0]), .busy(busy_v[0]), .error(err_v[0]), .arr_out(top_v[0]),
    .pop_data(pop_v[0]), .n(n_v[0]), .full(full_v[0]), .empty(empty_v[0]));

  heap_priority_queue #(.KEY_W(32), .DEPTH(7), .CNT_W(3), .MIN_HEAP(0)) dut_max (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .instruction(instruction), .key(key),
    .done(done_v[1]), .busy(busy_v[1]), .error(err_v[1]), .arr_out(top_v[1]),
    .pop_data(pop_v[1]), .n(n_v[1]), .full(full_v[1]), .empty(empty_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int w);
    @(negedge clk);
    rst_v[w] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_v[w] = 1'b0;
  endtask

  // Latency counts negedges after the start edge; returns -1 if done never arrives.
  task automatic cmd(input int w, input logic [1:0] ins, input logic [31:0] k,
                     output int l, output logic er);
    @(negedge clk);
    instruction = ins;
    key         = k;
    start_v[w]  = 1'b1;
    @(negedge clk);
    start_v[w] = 1'b0;
    l = 1;
    while (!done_v[w] && l < 40) begin
      @(negedge clk);
      l++;
    end
    if (!done_v[w]) l = -1;
    er = err_v[w];
    $display("txn dut=%0d op=%0d key=%0h lat=%0d err=%0b top=%0h pop=%0h n=%0d",
             w, ins, k, l, er, top_v[w], pop_v[w], n_v[w]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pop_exp [4];
    logic [31:0] repl_exp [3];
    pop_exp  = '{32'd1, 32'd3, 32'd5, 32'd8};
    repl_exp = '{32'd4, 32'd6, 32'd7};
    instruction = NOP;
    key = '0;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b0;
      start_v[i] = 1'b0;
    end
    do_reset(0);
    do_reset(1);

    check("rst_n", n_v[0], 0);
    check("rst_empty", empty_v[0], 1);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_err", err_v[0], 0);
    check("rst_pop", pop_v[0], 0);
    check("rst_top", top_v[0], 0);

    cmd(0, NOP, 0, lat, e);
    check("nop_lat", lat, 1);
    check("nop_err", e, 0);

    // PUSH 5,3,8,1
    cmd(0, PUSH, 5, lat, e);
    check("t1_top5", top_v[0], 5);
    check("t1_lat5", lat, 2);
    cmd(0, PUSH, 3, lat, e);
    check("t1_top3", top_v[0], 3);
    check("t1_lat3", lat, 3);
    cmd(0, PUSH, 8, lat, e);
    check("t1_top8", top_v[0], 3);
    cmd(0, PUSH, 1, lat, e);
    check("t1_top1", top_v[0], 1);
    check("t1_lat1", lat, 4);
    check("t1_n", n_v[0], 4);

    for (int i = 0; i < 4; i++) begin
      cmd(0, POP, 0, lat, e);
      check("t2_pop", pop_v[0], pop_exp[i]);
      check("t2_n", n_v[0], 32'(3 - i));
    end
    check("t2_empty", empty_v[0], 1);
    check("t2_top0", top_v[0], 0);
    cmd(0, POP, 0, lat, e);
    check("t2_uf_err", e, 1);
    check("t2_uf_lat", lat, 1);
    check("t2_uf_n", n_v[0], 0);

    for (int i = 7; i >= 1; i--) cmd(0, PUSH, 32'(i), lat, e);
    check("t3_full", full_v[0], 1);
    check("t3_n", n_v[0], 7);
    check("t3_top", top_v[0], 1);
    cmd(0, PUSH, 9, lat, e);
    check("t3_of_err", e, 1);
    check("t3_of_lat", lat, 1);
    check("t3_of_n", n_v[0], 7);
    check("t3_of_top", top_v[0], 1);
    cmd(0, POP, 0, lat, e);
    check("t3_pop", pop_v[0], 1);
    check("t3_notfull", full_v[0], 0);

    do_reset(0);
    cmd(0, PUSH, 2, lat, e);
    cmd(0, PUSH, 4, lat, e);
    cmd(0, PUSH, 6, lat, e);
    cmd(0, REPL, 7, lat, e);
    check("t4_pop", pop_v[0], 2);
    check("t4_top", top_v[0], 4);
    check("t4_n", n_v[0], 3);
    check("t4_lat", lat, 3);
    check("t4_err", e, 0);
    for (int i = 0; i < 3; i++) begin
      cmd(0, POP, 0, lat, e);
      check("t4_drain", pop_v[0], repl_exp[i]);
    end
    cmd(0, REPL, 9, lat, e);
    check("t4_repl_empty_err", e, 1);
    check("t4_repl_empty_n", n_v[0], 0);
    check("t4_pop_held", pop_v[0], 7);

    // equal keys never swap
    cmd(0, PUSH, 4, lat, e);
    cmd(0, PUSH, 4, lat, e);
    check("eq_lat", lat, 2);

    // start while busy is ignored
    do_reset(0);
    cmd(0, PUSH, 5, lat, e);
    @(negedge clk);
    instruction = PUSH;
    key = 3;
    start_v[0] = 1'b1;
    @(negedge clk);
    check("t6_busy", busy_v[0], 1);
    key = 99;
    @(negedge clk);
    start_v[0] = 1'b0;
    lat = 0;
    while (!done_v[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t6_done_seen", done_v[0], 1);
    repeat (3) @(negedge clk);
    check("t6_n", n_v[0], 2);
    check("t6_top", top_v[0], 3);
    check("t6_idle", busy_v[0], 0);

    // reset during SIFT_UP aborts
    @(negedge clk);
    instruction = PUSH;
    key = 1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("t6_sift_busy", busy_v[0], 1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("t6_rst_n", n_v[0], 0);
    check("t6_rst_busy", busy_v[0], 0);
    check("t6_rst_done", done_v[0], 0);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_done", done_v[0], 0);
    end

    // max heap
    cmd(1, PUSH, 10, lat, e);
    check("t5_top10", top_v[1], 10);
    cmd(1, PUSH, 30, lat, e);
    check("t5_top30", top_v[1], 30);
    cmd(1, PUSH, 20, lat, e);
    check("t5_top30b", top_v[1], 30);
    do_reset(1);
    cmd(1, PUSH, 32'hFFFF_FFFF, lat, e);
    cmd(1, PUSH, 1, lat, e);
`ifdef HEAP_SIGNED_EN
    check("t5_signed", top_v[1], 1);
`else
    check("t5_unsigned", top_v[1], 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
